// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, IR field positions, fetch FSM encoding
// and the default reset PC.
package sisc_pkg;

   localparam logic [3:0] NOOP   = 4'd0;
   localparam logic [3:0] REG_OP = 4'd1;
   localparam logic [3:0] REG_IM = 4'd2;
   localparam logic [3:0] BRA    = 4'd4;
   localparam logic [3:0] BRR    = 4'd5;
   localparam logic [3:0] BNE    = 4'd6;
   localparam logic [3:0] BNR    = 4'd7;
   localparam logic [3:0] HLT    = 4'd15;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 28;
   localparam int MM_MSB     = 27;
   localparam int MM_LSB     = 24;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;

   localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_WAIT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus. Handshake: imem_req pulses for one cycle with
// imem_addr valid; imem_addr stays stable until the response, and imem_rdata is
// taken on the first cycle imem_valid is high while the fetcher is waiting.
interface fetch_unit_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 32
);
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               imem_valid;

   modport master (output imem_req, imem_addr, input imem_rdata, imem_valid);
   modport slave  (input imem_req, imem_addr, output imem_rdata, imem_valid);
endinterface

// File: rtl/pc_next.sv
// Combinational next-PC selection: reset, increment, absolute or PC-relative
// branch target, all modulo 2^PC_W.
module pc_next #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic [PC_W-1:0] pc,
   input  logic [15:0]     imm,
   input  logic            pc_rst,
   input  logic            pc_write,
   input  logic            pc_sel,
   input  logic            br_sel,
   output logic [PC_W-1:0] next_pc
);

   always_comb begin
      next_pc = pc;
      if (pc_rst) begin
         next_pc = RESET_PC;
      end else if (pc_write) begin
         if (!pc_sel)
            next_pc = pc + PC_W'(1);
         else if (br_sel)
            next_pc = PC_W'(imm);
         else
            next_pc = pc + PC_W'($signed(imm));
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// PC / IR datapath with a three-state instruction fetch engine.
// Optional fetch watchdog enabled by defining IMEM_TIMEOUT_EN.
module fetch_unit
   import sisc_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
   parameter int              TIMEOUT  = 8
) (
   input  logic               clk,
   input  logic               rst_f,
   input  logic               pc_rst,
   input  logic               pc_write,
   input  logic               pc_sel,
   input  logic               br_sel,
   input  logic               ir_load,
   fetch_unit_if.master       imem,
   output logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] ir,
   output logic [3:0]         opcode,
   output logic [3:0]         mm,
   output logic [15:0]        imm,
   output logic               fetch_busy,
   output logic               fetch_err,
   output fetch_state_t       fetch_state
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_d;
   logic            take_load;
   logic            data_done;
   logic            timed_out;

   // pc_rst aborts any fetch, so it also blocks a fetch from starting.
   assign take_load = (state_q == FETCH_IDLE) && ir_load && !pc_rst;
   assign data_done = (state_q == FETCH_WAIT) && imem.imem_valid && !pc_rst;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) state_q <= FETCH_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (pc_rst) begin
         state_d = FETCH_IDLE;
      end else begin
         case (state_q)
            FETCH_IDLE: if (ir_load) state_d = FETCH_REQ;
            FETCH_REQ:  state_d = FETCH_WAIT;
            FETCH_WAIT: if (imem.imem_valid || timed_out) state_d = FETCH_IDLE;
            default:    state_d = FETCH_IDLE;
         endcase
      end
   end

   always_comb begin
      imem.imem_req = (state_q == FETCH_REQ);
      fetch_busy    = (state_q != FETCH_IDLE);
      fetch_state   = state_q;
   end

   pc_next #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc_next (
      .pc       (pc),
      .imm      (imm),
      .pc_rst   (pc_rst),
      .pc_write (pc_write),
      .pc_sel   (pc_sel),
      .br_sel   (br_sel),
      .next_pc  (pc_d)
   );

   // imem_addr takes the pre-update pc, so ir_load + pc_write is a normal fetch.
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         pc             <= RESET_PC;
         ir             <= '0;
         imem.imem_addr <= '0;
      end else begin
         pc <= pc_d;
         if (take_load)
            imem.imem_addr <= pc;
         if (data_done)
            ir <= imem.imem_rdata;
         else if (timed_out)
            ir <= '0;
      end
   end

   assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
   assign mm     = ir[MM_MSB:MM_LSB];
   assign imm    = ir[IMM_MSB:IMM_LSB];

`ifdef IMEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   // Abort on the TIMEOUT-th waiting cycle that still has no response.
   assign timed_out = (state_q == FETCH_WAIT) && !imem.imem_valid && !pc_rst &&
                      (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if ((state_q == FETCH_WAIT) && !pc_rst && !imem.imem_valid && !timed_out)
            wait_cnt <= wait_cnt + CNT_W'(1);
         else
            wait_cnt <= '0;
         if (timed_out)
            err_q <= 1'b1;
      end
   end

   assign fetch_err = err_q;
`else
   localparam int unused_timeout = TIMEOUT;

   assign timed_out = 1'b0;
   assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, multi-cycle corner sequences,
// then random traffic against a cycle-level reference model.
module tb_fetch_unit;
   import sisc_pkg::*;

   localparam int TMO = 4;

   logic         clk;
   logic         rst_f;
   logic         pc_rst, pc_write, pc_sel, br_sel, ir_load;
   logic [15:0]  pc;
   logic [31:0]  ir;
   logic [3:0]   opcode, mm;
   logic [15:0]  imm;
   logic         fetch_busy, fetch_err;
   fetch_state_t fetch_state;

   fetch_unit_if #(.PC_W(16), .INSTR_W(32)) imem_bus ();

   fetch_unit #(.PC_W(16), .INSTR_W(32), .RESET_PC(16'h0000), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst_f       (rst_f),
      .pc_rst      (pc_rst),
      .pc_write    (pc_write),
      .pc_sel      (pc_sel),
      .br_sel      (br_sel),
      .ir_load     (ir_load),
      .imem        (imem_bus),
      .pc          (pc),
      .ir          (ir),
      .opcode      (opcode),
      .mm          (mm),
      .imm         (imm),
      .fetch_busy  (fetch_busy),
      .fetch_err   (fetch_err),
      .fetch_state (fetch_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r, input bit w, input bit s, input bit b,
                        input bit l, input bit v, input logic [31:0] d);
      pc_rst   = r;
      pc_write = w;
      pc_sel   = s;
      br_sel   = b;
      ir_load  = l;
      imem_bus.imem_valid = v;
      imem_bus.imem_rdata = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          r, w, s, b, l, v;
      logic [31:0] d;
      logic [15:0] e_pc;
      logic [31:0] e_ir;
      bit          e_req, e_busy;
      logic [15:0] e_addr;
   } vec_t;

   function automatic vec_t mk(bit r, bit w, bit s, bit b, bit l, bit v, logic [31:0] d,
                               logic [15:0] e_pc, logic [31:0] e_ir, bit e_req,
                               bit e_busy, logic [15:0] e_addr);
      vec_t t;
      t.r = r; t.w = w; t.s = s; t.b = b; t.l = l; t.v = v; t.d = d;
      t.e_pc = e_pc; t.e_ir = e_ir; t.e_req = e_req; t.e_busy = e_busy; t.e_addr = e_addr;
      return t;
   endfunction

   localparam int NV = 31;
   vec_t vec[NV];

   // Reference model state: age -1 = idle, 0 = request cycle, n>0 = n-th wait cycle.
   int          m_pc, m_age, m_addr;
   logic [31:0] m_ir;
   bit          m_err;

   task automatic model_edge(input bit r, input bit w, input bit s, input bit b,
                             input bit l, input bit v, input logic [31:0] d);
      int im, off, n_pc;
      im  = int'(m_ir[15:0]);
      off = (im >= 32768) ? im - 65536 : im;
      n_pc = m_pc;
      if (r)       n_pc = 0;
      else if (w)  n_pc = !s ? m_pc + 1 : (b ? im : m_pc + off);
      n_pc = n_pc & 'hFFFF;
      if (r) begin
         m_age = -1;
      end else if (m_age == -1) begin
         if (l) begin m_age = 0; m_addr = m_pc; end
      end else if (m_age == 0) begin
         m_age = 1;
      end else if (v) begin
         m_ir  = d;
         m_age = -1;
      end else begin
`ifdef IMEM_TIMEOUT_EN
         if (m_age == TMO) begin
            m_ir  = '0;
            m_err = 1'b1;
            m_age = -1;
         end else
`endif
         m_age++;
      end
      m_pc = n_pc;
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion at %0t", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int req_cnt, ir_chg;
      logic [31:0] prev_ir;

      rst_f = 1'b0;
      drive(0, 0, 0, 0, 0, 0, '0);
      #12;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_ir", ir, 32'h0);
      chk("rst_req", imem_bus.imem_req, 1'b0);
      chk("rst_addr", imem_bus.imem_addr, 16'h0000);
      chk("rst_busy", fetch_busy, 1'b0);
      chk("rst_err", fetch_err, 1'b0);
      chk("rst_state", fetch_state, FETCH_IDLE);
      #1 rst_f = 1'b1;

      //          r w s b l v  rdata          pc       ir             req busy addr
      vec[0]  = mk(0,1,0,0,0,0, 32'h0,        16'h0001, 32'h0,        0, 0, 16'h0000);
      vec[1]  = mk(0,1,0,0,0,0, 32'h0,        16'h0002, 32'h0,        0, 0, 16'h0000);
      vec[2]  = mk(0,1,0,0,0,0, 32'h0,        16'h0003, 32'h0,        0, 0, 16'h0000);
      vec[3]  = mk(0,1,0,0,0,0, 32'h0,        16'h0004, 32'h0,        0, 0, 16'h0000);
      vec[4]  = mk(0,1,0,0,0,0, 32'h0,        16'h0005, 32'h0,        0, 0, 16'h0000);
      vec[5]  = mk(0,1,0,0,1,0, 32'h0,        16'h0006, 32'h0,        1, 1, 16'h0005);
      vec[6]  = mk(0,0,0,0,1,0, 32'h0,        16'h0006, 32'h0,        0, 1, 16'h0005);
      vec[7]  = mk(0,0,0,0,0,1, 32'h11200003, 16'h0006, 32'h11200003, 0, 0, 16'h0005);
      vec[8]  = mk(0,0,0,0,1,0, 32'h0,        16'h0006, 32'h11200003, 1, 1, 16'h0006);
      vec[9]  = mk(0,0,0,0,0,1, 32'hDEADBEEF, 16'h0006, 32'h11200003, 0, 1, 16'h0006);
      vec[10] = mk(0,0,0,0,0,1, 32'h40000010, 16'h0006, 32'h40000010, 0, 0, 16'h0006);
      vec[11] = mk(0,1,1,1,0,0, 32'h0,        16'h0010, 32'h40000010, 0, 0, 16'h0006);
      vec[12] = mk(0,0,0,0,1,0, 32'h0,        16'h0010, 32'h40000010, 1, 1, 16'h0010);
      vec[13] = mk(0,0,0,0,0,0, 32'h0,        16'h0010, 32'h40000010, 0, 1, 16'h0010);
      vec[14] = mk(0,0,0,0,0,1, 32'h5000FFFC, 16'h0010, 32'h5000FFFC, 0, 0, 16'h0010);
      vec[15] = mk(0,1,1,0,0,0, 32'h0,        16'h000C, 32'h5000FFFC, 0, 0, 16'h0010);
      vec[16] = mk(0,0,0,0,1,0, 32'h0,        16'h000C, 32'h5000FFFC, 1, 1, 16'h000C);
      vec[17] = mk(0,0,0,0,0,0, 32'h0,        16'h000C, 32'h5000FFFC, 0, 1, 16'h000C);
      vec[18] = mk(0,0,0,0,0,1, 32'h40000040, 16'h000C, 32'h40000040, 0, 0, 16'h000C);
      vec[19] = mk(0,1,1,1,0,0, 32'h0,        16'h0040, 32'h40000040, 0, 0, 16'h000C);
      vec[20] = mk(0,0,0,0,1,0, 32'h0,        16'h0040, 32'h40000040, 1, 1, 16'h0040);
      vec[21] = mk(0,0,0,0,0,0, 32'h0,        16'h0040, 32'h40000040, 0, 1, 16'h0040);
      vec[22] = mk(0,0,0,0,0,1, 32'h4000FFFF, 16'h0040, 32'h4000FFFF, 0, 0, 16'h0040);
      vec[23] = mk(0,1,1,1,0,0, 32'h0,        16'hFFFF, 32'h4000FFFF, 0, 0, 16'h0040);
      vec[24] = mk(0,1,0,0,0,0, 32'h0,        16'h0000, 32'h4000FFFF, 0, 0, 16'h0040);
      vec[25] = mk(0,1,0,0,0,0, 32'h0,        16'h0001, 32'h4000FFFF, 0, 0, 16'h0040);
      vec[26] = mk(1,1,0,0,0,0, 32'h0,        16'h0000, 32'h4000FFFF, 0, 0, 16'h0040);
      vec[27] = mk(0,0,0,0,1,0, 32'h0,        16'h0000, 32'h4000FFFF, 1, 1, 16'h0000);
      vec[28] = mk(0,0,0,0,0,0, 32'h0,        16'h0000, 32'h4000FFFF, 0, 1, 16'h0000);
      vec[29] = mk(1,0,0,0,0,0, 32'h0,        16'h0000, 32'h4000FFFF, 0, 0, 16'h0000);
      vec[30] = mk(0,0,0,0,0,1, 32'h12345678, 16'h0000, 32'h4000FFFF, 0, 0, 16'h0000);

      for (int i = 0; i < NV; i++) begin
         drive(vec[i].r, vec[i].w, vec[i].s, vec[i].b, vec[i].l, vec[i].v, vec[i].d);
         step();
         chk($sformatf("vec%0d_pc", i), pc, vec[i].e_pc);
         chk($sformatf("vec%0d_ir", i), ir, vec[i].e_ir);
         chk($sformatf("vec%0d_req", i), imem_bus.imem_req, vec[i].e_req);
         chk($sformatf("vec%0d_busy", i), fetch_busy, vec[i].e_busy);
         chk($sformatf("vec%0d_addr", i), imem_bus.imem_addr, vec[i].e_addr);
         chk($sformatf("vec%0d_opcode", i), opcode, vec[i].e_ir[31:28]);
         chk($sformatf("vec%0d_mm", i), mm, vec[i].e_ir[27:24]);
         chk($sformatf("vec%0d_imm", i), imm, vec[i].e_ir[15:0]);
      end

      // Repeated ir_load while busy, memory answering on the third wait cycle.
      req_cnt = 0;
      ir_chg  = 0;
      prev_ir = ir;
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 0, 0, k < 4, k == 4, 32'hA5A50001);
         step();
         if (imem_bus.imem_req) req_cnt++;
         if (ir !== prev_ir) ir_chg++;
         prev_ir = ir;
      end
      chk("coll_req_pulses", req_cnt, 1);
      chk("coll_ir_updates", ir_chg, 1);
      chk("coll_ir", ir, 32'hA5A50001);
      chk("coll_busy", fetch_busy, 1'b0);

`ifdef IMEM_TIMEOUT_EN
      drive(0, 0, 0, 0, 1, 0, '0);
      step();
      drive(0, 0, 0, 0, 0, 0, '0);
      for (int k = 0; k < 4; k++) step();
      chk("tmo_busy_before", fetch_busy, 1'b1);
      step();
      chk("tmo_busy", fetch_busy, 1'b0);
      chk("tmo_ir", ir, 32'h0);
      chk("tmo_err", fetch_err, 1'b1);
      drive(1, 0, 0, 0, 0, 0, '0);
      step();
      chk("tmo_err_sticky", fetch_err, 1'b1);
`endif

      // Asynchronous reset in the middle of a fetch.
      drive(0, 1, 0, 0, 0, 0, '0);
      step();
      drive(0, 0, 0, 0, 1, 0, '0);
      step();
      drive(0, 0, 0, 0, 0, 0, '0);
      step();
      #2 rst_f = 1'b0;
      #1;
      chk("arst_pc", pc, 16'h0000);
      chk("arst_ir", ir, 32'h0);
      chk("arst_req", imem_bus.imem_req, 1'b0);
      chk("arst_busy", fetch_busy, 1'b0);
      chk("arst_err", fetch_err, 1'b0);
      drive(0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
      #2 rst_f = 1'b1;
      step();
      chk("arst_late_ir", ir, 32'h0);
      chk("arst_late_busy", fetch_busy, 1'b0);

      m_pc = 0; m_ir = '0; m_age = -1; m_addr = 0; m_err = 1'b0;
      for (int n = 0; n < 1500; n++) begin
         bit r, w, s, b, l, v;
         logic [31:0] d;
         r = ($urandom_range(0, 19) == 0);
         w = ($urandom_range(0, 2) == 0);
         s = $urandom_range(0, 1);
         b = $urandom_range(0, 1);
         l = ($urandom_range(0, 2) == 0);
         v = $urandom_range(0, 1);
         d = $urandom;
         drive(r, w, s, b, l, v, d);
         model_edge(r, w, s, b, l, v, d);
         step();
         chk("rnd_pc", pc, m_pc[15:0]);
         chk("rnd_ir", ir, m_ir);
         chk("rnd_req", imem_bus.imem_req, m_age == 0);
         chk("rnd_busy", fetch_busy, m_age != -1);
         chk("rnd_addr", imem_bus.imem_addr, m_addr[15:0]);
         chk("rnd_err", fetch_err, m_err);
         chk("rnd_opcode", opcode, m_ir[31:28]);
         chk("rnd_imm", imm, m_ir[15:0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter and instruction-register datapath that sits directly downstream of the SISC control FSM. It consumes ctrl's pc_rst/pc_write/pc_sel/br_sel/ir_load strobes, owns the PC, and fetches from instruction memory over a req/valid handshake. It holds the IR and feeds opcode/mm/imm back to ctrl and the datapath. Branch target arithmetic lives here (relative = PC + signed offset, absolute = imm).

Parameters:
PC_W, 16, PC and imem address width
INSTR_W, 32, instruction/IR width
RESET_PC, 16'h0000, PC value after rst_f or pc_rst
TIMEOUT, 8, max WAIT cycles before abort (used only with IMEM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_f  in  1  asynchronous, active-low reset
pc_rst  in  1  synchronous PC reset to RESET_PC
pc_write  in  1  PC update enable
pc_sel  in  1  0 = PC+1, 1 = branch target
br_sel  in  1  0 = relative target, 1 = absolute target
ir_load  in  1  start a fetch at the current PC
imem_req  out  1  fetch request, one-cycle pulse
imem_addr  out  PC_W  fetch address, held from REQ through WAIT
imem_rdata  in  INSTR_W  instruction data
imem_valid  in  1  rdata valid, sampled only in WAIT
pc  out  PC_W  current PC
ir  out  INSTR_W  instruction register
opcode  out  4  ir[31:28]
mm  out  4  ir[27:24]
imm  out  16  ir[15:0]
fetch_busy  out  1  fetch outstanding (state != IDLE)
fetch_err  out  1  sticky timeout flag; tied 0 without the macro

Behaviour:
- Reset (rst_f low, asynchronous): pc = RESET_PC, ir = 0, state = IDLE, imem_req = 0, imem_addr = 0, fetch_err = 0, timeout counter = 0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when ir_load = 1. The current pc is captured into imem_addr on that edge.
  - REQ: imem_req = 1 for exactly one cycle, then always -> WAIT.
  - WAIT: on imem_valid = 1, ir <= imem_rdata and -> IDLE.
- Latency: with ir_load at edge N and imem_valid asserted in the first WAIT cycle, the IR updates at edge N+2.
- ir_load while fetch_busy = 1 is ignored. No queueing; the in-flight fetch is unaffected.
- imem_valid in IDLE or REQ is ignored.
- PC update priority, evaluated every edge independent of FSM state:
  1. pc_rst: pc <= RESET_PC.
  2. pc_write & !pc_sel: pc <= pc + 1.
  3. pc_write & pc_sel & br_sel: pc <= imm.
  4. pc_write & pc_sel & !br_sel: pc <= pc + sign_extend(imm).
  5. Otherwise pc holds.
- Arithmetic is modulo 2^PC_W: 16'hFFFF + 1 = 16'h0000, and 16'h0002 + 16'hFFFD = 16'hFFFF.
- The relative target uses the PC value already incremented by the fetch.
- ir_load and pc_write in the same edge: imem_addr takes the old pc and pc takes the new value. This is the normal fetch cycle.
- pc_rst during REQ/WAIT aborts the fetch. State -> IDLE, imem_req deasserts, ir is unchanged, and a later imem_valid is dropped.
- rst_f mid-fetch behaves the same, plus the full reset.
- opcode/mm/imm are combinational slices of ir, so they change only when ir changes.

Optional Feature:
Macro IMEM_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If imem_valid has not arrived after TIMEOUT WAIT cycles:
  - ir <= 0 (NOOP), state -> IDLE, fetch_err <= 1.
  - fetch_err is sticky until rst_f. pc_rst does not clear it.
- Undefined: WAIT waits indefinitely, no counter is instantiated, and fetch_err is constant 0.

Decomposition:
- Shared package sisc_pkg:
  - Opcode constants: NOOP = 0, REG_OP = 1, REG_IM = 2, BRA = 4, BRR = 5, BNE = 6, BNR = 7, HLT = 15.
  - IR field bit positions (opcode 31:28, mm 27:24, imm 15:0).
  - Fetch FSM state encoding.
  - RESET_PC default.
- Sub-module pc_next: purely combinational next-PC mux plus adder, instantiated once.

Test Plan:
- Reset: rst_f low mid-WAIT -> pc = 0000, ir = 0, imem_req = 0, fetch_busy = 0 immediately; late imem_valid ignored.
- Sequential fetch: pc = 0005, ir_load + pc_write (pc_sel = 0); memory returns 32'h1120_0003 one cycle after req -> imem_addr = 0005, pc = 0006, ir = 11200003, opcode = 1, imm = 0003 at edge N+2.
- Relative branch: pc = 0010, imm = FFFC, pc_write + pc_sel, br_sel = 0 -> pc = 000C. Absolute with imm = 0040, br_sel = 1 -> pc = 0040.
- Wrap and priority: pc = FFFF, pc_write -> pc = 0000. pc_rst and pc_write together -> pc = RESET_PC.
- Busy collision: second ir_load while WAIT with 3-cycle memory latency -> single imem_req pulse, single IR update.
- IMEM_TIMEOUT_EN with TIMEOUT = 4: no imem_valid -> after 4 WAIT cycles ir = 0, fetch_err = 1, state IDLE; fetch_err still 1 after pc_rst.
